// File: rtl/reset_pkg.sv
// ==========================================================================
// reset_pkg: shared state encoding and widths for the board reset source.
// Revision 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

package reset_pkg;

  localparam int STATE_W       = 2;
  localparam int RESET_COUNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_generator_if.sv
// ==========================================================================
// reset_generator_if: board-side inputs and reset request outputs.
// Revision 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

interface reset_generator_if;
  import reset_pkg::*;

  logic                     button_n_i;
  logic                     pll_locked_i;
  logic                     reset_n_o;
  state_e                   state_o;
  logic [RESET_COUNT_W-1:0] reset_count_o;

  modport master (
    output button_n_i,
    output pll_locked_i,
    input  reset_n_o,
    input  state_o,
    input  reset_count_o
  );

  modport slave (
    input  button_n_i,
    input  pll_locked_i,
    output reset_n_o,
    output state_o,
    output reset_count_o
  );

endinterface

`default_nettype wire

// File: rtl/reset_generator_debouncer.sv
// ==========================================================================
// debouncer: 2-flop synchronizer plus stability counter for an active-low button.
// Revision 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module debouncer
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic raw_n_i,
  output logic stable_n_o,
  output logic press_o
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_n_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // The counter measures how long the input has disagreed with the debounced
  // value; any return to agreement (a bounce) restarts it.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      press_d  = stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_n_o = stable_q;
  assign press_o    = press_q;

endmodule

`default_nettype wire

// File: rtl/reset_generator.sv
// ==========================================================================
// reset_generator: board reset source combining button, PLL lock and min pulse.
// Revision 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module reset_generator
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 65536,
  parameter int MIN_PULSE_CYCLES   = 1024,
  parameter int LOCK_STABLE_CYCLES = 4096
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  reset_generator_if.slave   bus
);

  localparam int                 PULSE_W    = cnt_width(MIN_PULSE_CYCLES);
  localparam int                 LOCK_W     = cnt_width(LOCK_STABLE_CYCLES);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(MIN_PULSE_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_STABLE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || MIN_PULSE_CYCLES < 2 || LOCK_STABLE_CYCLES < 2) begin : g_param_check
    $error("reset_generator: all cycle parameters must be >= 2");
  end

  logic                     lock_meta_q;
  logic                     lock_sync_q;
  logic                     btn_stable_n;
  logic                     press;
  state_e                   state_q, state_d;
  logic [PULSE_W-1:0]       pulse_cnt_q, pulse_cnt_d;
  logic [LOCK_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic [RESET_COUNT_W-1:0] reset_cnt_q, reset_cnt_d;
  logic                     reset_n_q, reset_n_d;

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .raw_n_i    (bus.button_n_i),
    .stable_n_o (btn_stable_n),
    .press_o    (press)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      state_q     <= ST_ASSERT;
      pulse_cnt_q <= '0;
      lock_cnt_q  <= '0;
      reset_cnt_q <= '0;
      reset_n_q   <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_locked_i;
      lock_sync_q <= lock_meta_q;
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      reset_cnt_q <= reset_cnt_d;
      reset_n_q   <= reset_n_d;
    end
  end

  // A press in WAIT_LOCK outranks a coincident lock-stable release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ASSERT: begin
        if (pulse_cnt_q == PULSE_LAST && btn_stable_n)
          state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (press)
          state_d = ST_ASSERT;
        else if (lock_sync_q && lock_cnt_q == LOCK_LAST)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press || !lock_sync_q)
          state_d = ST_ASSERT;
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  // Counters read zero whenever their state is entered because they are
  // forced clear in every other state.
  always_comb begin
    pulse_cnt_d = '0;
    lock_cnt_d  = '0;
    reset_cnt_d = reset_cnt_q;
    reset_n_d   = (state_q == ST_RUN);

    if (state_q == ST_ASSERT)
      pulse_cnt_d = (pulse_cnt_q == PULSE_LAST) ? pulse_cnt_q : pulse_cnt_q + PULSE_W'(1);

    if (state_q == ST_WAIT_LOCK && lock_sync_q)
      lock_cnt_d = (lock_cnt_q == LOCK_LAST) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);

    if (state_q == ST_RUN && state_d == ST_ASSERT && reset_cnt_q != '1)
      reset_cnt_d = reset_cnt_q + RESET_COUNT_W'(1);
  end

  assign bus.reset_n_o     = reset_n_q;
  assign bus.state_o       = state_q;
  assign bus.reset_count_o = reset_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_generator.sv
// ==========================================================================
// tb_reset_generator: directed self-checking bench for reset_generator.
// Revision 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reset_generator;
  import reset_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  reset_generator_if rg_if ();

  reset_generator #(
    .DEBOUNCE_CYCLES    (4),
    .MIN_PULSE_CYCLES   (8),
    .LOCK_STABLE_CYCLES (5)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (rg_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n;
    n = 0;
    while (rg_if.state_o !== s && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(rg_if.state_o), 32'(s));
  endtask

  task automatic lock_blip();
    rg_if.pll_locked_i = 1'b0;
    tick();
    rg_if.pll_locked_i = 1'b1;
    wait_state(2'd0, "blip_leave_run");
    wait_state(2'd2, "blip_back_run");
  endtask

  initial begin
    logic [7:0] pat;

    // Power-up with lock present and button released
    rg_if.button_n_i   = 1'b1;
    rg_if.pll_locked_i = 1'b1;
    #2 reset_n = 1'b0;
    tick(3);
    check("rst_reset_n_o", 32'(rg_if.reset_n_o), 32'd0);
    check("rst_state",     32'(rg_if.state_o), 32'd0);
    check("rst_count",     32'(rg_if.reset_count_o), 32'd0);
    reset_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      check($sformatf("pu_state_e%0d", e), 32'(rg_if.state_o),
            (e < 8) ? 32'd0 : (e < 13) ? 32'd1 : 32'd2);
      check($sformatf("pu_rstn_e%0d", e), 32'(rg_if.reset_n_o), (e == 14) ? 32'd1 : 32'd0);
    end
    check("pu_count", 32'(rg_if.reset_count_o), 32'd0);

    // Power-up with lock absent for 30 cycles
    reset_n = 1'b0;
    rg_if.pll_locked_i = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(30);
    check("nolock_state", 32'(rg_if.state_o), 32'd1);
    check("nolock_rstn",  32'(rg_if.reset_n_o), 32'd0);
    rg_if.pll_locked_i = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("lock_state_e%0d", e), 32'(rg_if.state_o), (e < 7) ? 32'd1 : 32'd2);
      check($sformatf("lock_rstn_e%0d", e), 32'(rg_if.reset_n_o), (e == 8) ? 32'd1 : 32'd0);
    end

    // Short bouncy press: never stable for 4 synchronized cycles
    pat = 8'b0110_1000;
    for (int i = 0; i < 8; i++) begin
      rg_if.button_n_i = pat[i];
      tick();
    end
    rg_if.button_n_i = 1'b1;
    tick(10);
    check("glitch_rstn",  32'(rg_if.reset_n_o), 32'd1);
    check("glitch_state", 32'(rg_if.state_o), 32'd2);
    check("glitch_count", 32'(rg_if.reset_count_o), 32'd0);

    // Long press of 50 cycles
    rg_if.button_n_i = 1'b0;
    for (int e = 1; e <= 63; e++) begin
      if (e == 51) rg_if.button_n_i = 1'b1;
      tick();
      if (e == 6) check("press_state_e6", 32'(rg_if.state_o), 32'd2);
      if (e == 7) begin
        check("press_state_e7", 32'(rg_if.state_o), 32'd0);
        check("press_rstn_e7",  32'(rg_if.reset_n_o), 32'd1);
      end
      if (e == 8) begin
        check("press_rstn_e8",  32'(rg_if.reset_n_o), 32'd0);
        check("press_count_e8", 32'(rg_if.reset_count_o), 32'd1);
      end
      if (e == 50) begin
        check("held_state", 32'(rg_if.state_o), 32'd0);
        check("held_rstn",  32'(rg_if.reset_n_o), 32'd0);
      end
      if (e == 56) check("rel_state_e56", 32'(rg_if.state_o), 32'd0);
      if (e == 57) check("rel_state_e57", 32'(rg_if.state_o), 32'd1);
      if (e == 62) begin
        check("rel_state_e62", 32'(rg_if.state_o), 32'd2);
        check("rel_rstn_e62",  32'(rg_if.reset_n_o), 32'd0);
      end
      if (e == 63) check("rel_rstn_e63", 32'(rg_if.reset_n_o), 32'd1);
    end
    check("press_count_final", 32'(rg_if.reset_count_o), 32'd1);

    // Lock drop in the same cycle as the press strobe reaches the FSM
    rg_if.button_n_i = 1'b0;
    tick(4);
    rg_if.pll_locked_i = 1'b0;
    tick();
    rg_if.pll_locked_i = 1'b1;
    tick(2);
    check("both_state_e7", 32'(rg_if.state_o), 32'd0);
    check("both_rstn_e7",  32'(rg_if.reset_n_o), 32'd1);
    tick();
    check("both_count_e8", 32'(rg_if.reset_count_o), 32'd2);
    check("both_rstn_e8",  32'(rg_if.reset_n_o), 32'd0);
    tick(5);
    check("both_count_hold", 32'(rg_if.reset_count_o), 32'd2);
    rg_if.button_n_i = 1'b1;
    wait_state(2'd2, "both_back_run");
    check("both_count_run", 32'(rg_if.reset_count_o), 32'd2);

    // Saturation of the reset counter
    for (int i = 0; i < 252; i++) lock_blip();
    check("sat_count_254", 32'(rg_if.reset_count_o), 32'd254);
    for (int i = 0; i < 48; i++) lock_blip();
    check("sat_count_255", 32'(rg_if.reset_count_o), 32'd255);

    // Asynchronous power-on reset while in WAIT_LOCK
    rg_if.pll_locked_i = 1'b0;
    tick();
    rg_if.pll_locked_i = 1'b1;
    wait_state(2'd1, "async_reach_wait");
    check("async_pre_count", 32'(rg_if.reset_count_o), 32'd255);
    #3 reset_n = 1'b0;
    #1;
    check("async_rstn",  32'(rg_if.reset_n_o), 32'd0);
    check("async_state", 32'(rg_if.state_o), 32'd0);
    check("async_count", 32'(rg_if.reset_count_o), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
